subtract_mask_pipe: RTL

- Next-generation background-subtraction core for the frame pipeline. Sits between two 24-bit RGB input FIFOs (base/background and current image) and one output FIFO.
- Converts each RGB pixel pair to luma, takes the absolute difference and thresholds it into a binary foreground mask.
- Adds over the previous core: parametrised channel width, a runtime threshold latched per frame, frame position tracking, a frame-done pulse and a stall-safe 2-stage pipeline.

---
 rtl/subtract_mask_pipe.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/subtract_mask_pipe.sv
// Background subtraction: luma of base/image pixel pairs, |diff| > threshold -> mask.
// Optional foreground statistics with SUBTRACT_MASK_STATS_EN.
`timescale 1ns/1ps
module subtract_mask_pipe #(
  parameter int WIDTH   = 720,
  parameter int HEIGHT  = 540,
  parameter int CH_BITS = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [3*CH_BITS-1:0]                in_dout_base,
  input  logic                                in_empty_base,
  output logic                                in_rd_en_base,
  input  logic [3*CH_BITS-1:0]                in_dout_img,
  input  logic                                in_empty_img,
  output logic                                in_rd_en_img,
  input  logic [CH_BITS-1:0]                  thresh,
  output logic [CH_BITS-1:0]                  out_din,
  input  logic                                out_full,
  output logic                                out_wr_en,
  output logic                                frame_done,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   fg_count
);

  localparam int PW  = 3 * CH_BITS;
  localparam int YW  = CH_BITS + 8;
  localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YCW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FGW = $clog2(WIDTH * HEIGHT + 1);

  function automatic logic [CH_BITS-1:0] luma(input logic [PW-1:0] p);
    logic [YW-1:0] r, g, b, s;
    r = YW'(p[PW-1 -: CH_BITS]);
    g = YW'(p[2*CH_BITS-1 -: CH_BITS]);
    b = YW'(p[CH_BITS-1:0]);
    s = r * YW'(77) + g * YW'(151) + b * YW'(28);
    return s[YW-1:8];
  endfunction

  logic               s1_valid_q, s1_valid_d;
  logic [CH_BITS-1:0] yb_q, yb_d, yi_q, yi_d;
  logic               s2_valid_q, s2_valid_d;
  logic [CH_BITS-1:0] mask_q, mask_d;
  logic [CH_BITS-1:0] thr_q, thr_d;
  logic [XW-1:0]      in_x_q, in_x_d, out_x_q, out_x_d;
  logic [YCW-1:0]     in_y_q, in_y_d, out_y_q, out_y_d;
  logic [CH_BITS-1:0] diff;
  logic               stall, pop, wr, last_out;

  always_comb begin
    stall      = s2_valid_q && out_full;
    pop        = !reset && !in_empty_base && !in_empty_img && !stall;
    wr         = s2_valid_q && !out_full;
    last_out   = (out_x_q == XW'(WIDTH - 1)) && (out_y_q == YCW'(HEIGHT - 1));
    diff       = (yi_q >= yb_q) ? (yi_q - yb_q) : (yb_q - yi_q);
    s1_valid_d = s1_valid_q;
    yb_d       = yb_q;
    yi_d       = yi_q;
    s2_valid_d = s2_valid_q;
    mask_d     = mask_q;
    thr_d      = thr_q;
    in_x_d     = in_x_q;
    in_y_d     = in_y_q;
    out_x_d    = out_x_q;
    out_y_d    = out_y_q;
    if (!stall) begin
      s1_valid_d = pop;
      s2_valid_d = s1_valid_q;
      if (pop) begin
        yb_d = luma(in_dout_base);
        yi_d = luma(in_dout_img);
      end
      if (s1_valid_q) mask_d = (diff > thr_q) ? '1 : '0;
    end
    // threshold is frozen for the whole frame at its first pixel
    if (pop) begin
      if (in_x_q == '0 && in_y_q == '0) thr_d = thresh;
      if (in_x_q == XW'(WIDTH - 1)) begin
        in_x_d = '0;
        in_y_d = (in_y_q == YCW'(HEIGHT - 1)) ? '0 : in_y_q + 1'b1;
      end else begin
        in_x_d = in_x_q + 1'b1;
      end
    end
    if (wr) begin
      if (out_x_q == XW'(WIDTH - 1)) begin
        out_x_d = '0;
        out_y_d = (out_y_q == YCW'(HEIGHT - 1)) ? '0 : out_y_q + 1'b1;
      end else begin
        out_x_d = out_x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      yb_q       <= '0;
      yi_q       <= '0;
      s2_valid_q <= 1'b0;
      mask_q     <= '0;
      thr_q      <= '0;
      in_x_q     <= '0;
      in_y_q     <= '0;
      out_x_q    <= '0;
      out_y_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      yb_q       <= yb_d;
      yi_q       <= yi_d;
      s2_valid_q <= s2_valid_d;
      mask_q     <= mask_d;
      thr_q      <= thr_d;
      in_x_q     <= in_x_d;
      in_y_q     <= in_y_d;
      out_x_q    <= out_x_d;
      out_y_q    <= out_y_d;
    end
  end

  assign in_rd_en_base = pop;
  assign in_rd_en_img  = pop;
  assign out_wr_en     = wr;
  assign out_din       = mask_q;
  assign frame_done    = wr && last_out;

`ifdef SUBTRACT_MASK_STATS_EN
  logic [FGW-1:0] fg_cnt_q, fg_cnt_d, fg_count_q, fg_count_d, fg_inc;

  always_comb begin
    fg_cnt_d   = fg_cnt_q;
    fg_count_d = fg_count_q;
    fg_inc     = fg_cnt_q + FGW'(mask_q[0]);
    if (wr) begin
      if (last_out) begin
        fg_count_d = fg_inc;
        fg_cnt_d   = '0;
      end else begin
        fg_cnt_d   = fg_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fg_cnt_q   <= '0;
      fg_count_q <= '0;
    end else begin
      fg_cnt_q   <= fg_cnt_d;
      fg_count_q <= fg_count_d;
    end
  end

  assign fg_count = fg_count_q;
`else
  assign fg_count = '0;
`endif

endmodule
